pc_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_next_sel.sv | 42 ++++
 rtl/pc_unit.sv | 121 ++++++++++++
 tb/tb_pc_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program counter.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_BJ   = 2'd2,
        SEL_TRAP = 2'd3
    } pc_sel_e;

    localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC_DEF  = 32'h0000_0080;
    localparam int          PC_INC_DEF       = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority selector: picks the next-PC source and next state.
module pc_next_sel
    import pc_pkg::*;
(
    input  pc_state_e state_i,
    input  logic      boot_done_i,
    input  logic      trap_req_i,
    input  logic      c_if_flush_i,
    input  logic      halt_req_i,
    input  logic      c_PCWrite_i,
    input  logic      resume_i,
    output pc_sel_e   sel_o,
    output pc_state_e state_o
);

    always_comb begin
        sel_o   = SEL_HOLD;
        state_o = state_i;
        unique case (state_i)
            PC_BOOT: begin
                if (boot_done_i) state_o = PC_RUN;
            end
            PC_RUN: begin
                if (trap_req_i)        sel_o = SEL_TRAP;
                else if (c_if_flush_i) sel_o = SEL_BJ;
                else if (halt_req_i)   state_o = PC_HALT;
                else if (c_PCWrite_i)  sel_o = SEL_SEQ;
            end
            PC_HALT: begin
                // Only a trap or resume wakes the unit; flush/stall/halt are dropped.
                if (trap_req_i) begin
                    sel_o   = SEL_TRAP;
                    state_o = PC_RUN;
                end else if (resume_i) begin
                    state_o = PC_RUN;
                end
            end
            default: state_o = PC_BOOT;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with boot delay, halt/resume, traps and redirect count.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned flush targets into traps.
module pc_unit
    import pc_pkg::*;
#(
    parameter int             XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(PC_RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(PC_TRAP_VEC_DEF),
    parameter int             INC         = PC_INC_DEF,
    parameter int             BOOT_CYCLES = 2,
    parameter int             CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_PCWrite,
    input  logic             c_if_flush,
    input  logic [XLEN-1:0]  bj_next,
    input  logic             trap_req,
    input  logic             halt_req,
    input  logic             resume,
    output logic [XLEN-1:0]  out,
    output logic [XLEN-1:0]  normal_next,
    output logic             pc_valid,
    output logic [XLEN-1:0]  epc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] redirect_cnt
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic             misalign_pulse
`endif
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    pc_state_e        state_q, state_d;
    pc_sel_e          sel;
    logic [XLEN-1:0]  out_q, out_d, epc_q, epc_d, bj_tgt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0]    boot_q, boot_d;
    logic             valid_q, valid_d;
    logic             boot_done, mis, trap_eff, mis_q;

`ifdef PC_MISALIGN_TRAP_EN
    // A misaligned flush only acts as a trap when no real trap wins the cycle.
    assign mis    = (state_q == PC_RUN) && c_if_flush && (bj_next[1:0] != 2'b00) && !trap_req;
    assign bj_tgt = bj_next;
    assign misalign_pulse = mis_q;
`else
    assign mis    = 1'b0;
    assign bj_tgt = bj_next & ~XLEN'(3);
`endif

    assign trap_eff    = trap_req | mis;
    assign boot_done   = (boot_q == BW'(BOOT_CYCLES - 1));
    assign normal_next = out_q + XLEN'(INC);

    pc_next_sel u_sel (
        .state_i      (state_q),
        .boot_done_i  (boot_done),
        .trap_req_i   (trap_eff),
        .c_if_flush_i (c_if_flush),
        .halt_req_i   (halt_req),
        .c_PCWrite_i  (c_PCWrite),
        .resume_i     (resume),
        .sel_o        (sel),
        .state_o      (state_d)
    );

    always_comb begin
        out_d   = out_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        boot_d  = boot_q;
        valid_d = (state_d == PC_RUN);
        unique case (sel)
            SEL_SEQ:  out_d = normal_next;
            SEL_BJ:   out_d = bj_tgt;
            SEL_TRAP: begin
                out_d = TRAP_VEC;
                epc_d = mis ? bj_next : out_q;
            end
            default:  out_d = out_q;
        endcase
        if ((sel == SEL_BJ || sel == SEL_TRAP) && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        if (state_q == PC_BOOT)
            boot_d = boot_q + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_BOOT;
            out_q   <= RESET_VEC;
            epc_q   <= '0;
            cnt_q   <= '0;
            boot_q  <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            valid_q <= valid_d;
            mis_q   <= mis;
        end
    end

    assign out          = out_q;
    assign epc          = epc_q;
    assign pc_valid     = valid_q;
    assign state        = state_q;
    assign redirect_cnt = cnt_q;

`ifndef PC_MISALIGN_TRAP_EN
    logic unused_mis_q;
    assign unused_mis_q = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (small counter width to reach saturation).
module tb_pc_unit;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst;
    logic             c_PCWrite;
    logic             c_if_flush;
    logic [31:0]      bj_next;
    logic             trap_req;
    logic             halt_req;
    logic             resume;
    logic [31:0]      out;
    logic [31:0]      normal_next;
    logic             pc_valid;
    logic [31:0]      epc;
    logic [1:0]       state;
    logic [CNT_W-1:0] redirect_cnt;
`ifdef PC_MISALIGN_TRAP_EN
    logic             misalign_pulse;
`endif

    pc_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .c_PCWrite    (c_PCWrite),
        .c_if_flush   (c_if_flush),
        .bj_next      (bj_next),
        .trap_req     (trap_req),
        .halt_req     (halt_req),
        .resume       (resume),
        .out          (out),
        .normal_next  (normal_next),
        .pc_valid     (pc_valid),
        .epc          (epc),
        .state        (state),
        .redirect_cnt (redirect_cnt)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_pulse (misalign_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        trap, flush, halt, res, pcw;
        logic [31:0] bj;
        logic [31:0] e_out;
        logic        e_v;
        logic [1:0]  e_st;
        logic [31:0] e_epc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tv[28];
    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(logic t, logic f, logic h, logic r, logic w, logic [31:0] b,
                                logic [31:0] o, logic v, logic [1:0] s, logic [31:0] e, logic [2:0] c);
        vec_t x;
        x.trap = t; x.flush = f; x.halt = h; x.res = r; x.pcw = w; x.bj = b;
        x.e_out = o; x.e_v = v; x.e_st = s; x.e_epc = e; x.e_cnt = c;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic f, input logic h, input logic r,
                         input logic w, input logic [31:0] b);
        trap_req = t; c_if_flush = f; halt_req = h; resume = r; c_PCWrite = w; bj_next = b;
    endtask

    task automatic chk_all(input string nm, input logic [31:0] o, input logic v,
                           input logic [1:0] s, input logic [31:0] e, input logic [2:0] c);
        chk({nm, ".out"},   out, o);
        chk({nm, ".nn"},    normal_next, o + 32'd4);
        chk({nm, ".valid"}, {31'd0, pc_valid}, {31'd0, v});
        chk({nm, ".state"}, {30'd0, state}, {30'd0, s});
        chk({nm, ".epc"},   epc, e);
        chk({nm, ".cnt"},   {29'd0, redirect_cnt}, {29'd0, c});
    endtask

    initial begin
        //          trap flush halt res pcw bj            out           v  st  epc  cnt
        tv[0]  = mk(1, 1, 0, 0, 1, 32'h100,      32'h0,        0, 0, 0,     0); // ignored in BOOT
        tv[1]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 0,     0);
        tv[2]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h4,        1, 1, 0,     0);
        tv[3]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h8,        1, 1, 0,     0);
        tv[4]  = mk(0, 0, 0, 0, 1, 32'h0,        32'hC,        1, 1, 0,     0);
        tv[5]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h10,       1, 1, 0,     0);
        tv[6]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h10,       1, 1, 0,     0);
        tv[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h10,       1, 1, 0,     0);
        tv[8]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h10,       1, 1, 0,     0);
        tv[9]  = mk(0, 1, 0, 0, 0, 32'h40,       32'h40,       1, 1, 0,     1);
        tv[10] = mk(0, 1, 0, 0, 1, 32'h20,       32'h20,       1, 1, 0,     2);
        tv[11] = mk(1, 1, 0, 0, 1, 32'h100,      32'h80,       1, 1, 32'h20, 3);
        tv[12] = mk(0, 0, 0, 0, 1, 32'h0,        32'h84,       1, 1, 32'h20, 3);
        tv[13] = mk(0, 1, 0, 0, 1, 32'h8,        32'h8,        1, 1, 32'h20, 4);
        tv[14] = mk(0, 0, 1, 0, 1, 32'h0,        32'h8,        0, 2, 32'h20, 4);
        tv[15] = mk(0, 1, 0, 0, 1, 32'h40,       32'h8,        0, 2, 32'h20, 4);
        tv[16] = mk(0, 1, 1, 0, 0, 32'h40,       32'h8,        0, 2, 32'h20, 4);
        tv[17] = mk(0, 1, 0, 0, 1, 32'h40,       32'h8,        0, 2, 32'h20, 4);
        tv[18] = mk(0, 0, 1, 0, 1, 32'h0,        32'h8,        0, 2, 32'h20, 4);
        tv[19] = mk(0, 0, 0, 1, 1, 32'h0,        32'h8,        1, 1, 32'h20, 4);
        tv[20] = mk(0, 0, 0, 0, 1, 32'h0,        32'hC,        1, 1, 32'h20, 4);
        tv[21] = mk(0, 1, 0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 32'h20, 5);
        tv[22] = mk(0, 0, 0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h20, 5);
        tv[23] = mk(1, 0, 1, 0, 1, 32'h0,        32'h80,       1, 1, 32'h0, 6);
        tv[24] = mk(0, 1, 0, 0, 1, 32'h30,       32'h30,       1, 1, 32'h0, 7);
        tv[25] = mk(0, 0, 1, 0, 1, 32'h0,        32'h30,       0, 2, 32'h0, 7);
        tv[26] = mk(1, 0, 0, 0, 1, 32'h0,        32'h80,       1, 1, 32'h30, 7); // saturates
        tv[27] = mk(0, 1, 0, 0, 1, 32'h44,       32'h44,       1, 1, 32'h30, 7);

        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h0);
        cyc();
        cyc();
        chk_all("reset", 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            drive(tv[i].trap, tv[i].flush, tv[i].halt, tv[i].res, tv[i].pcw, tv[i].bj);
            cyc();
            chk_all($sformatf("v%0d", i), tv[i].e_out, tv[i].e_v, tv[i].e_st, tv[i].e_epc, tv[i].e_cnt);
        end

        // Reset mid-RUN overrides a simultaneous trap and flush.
        rst = 1'b1;
        drive(1, 1, 0, 0, 1, 32'h100);
        cyc();
        chk_all("midrst", 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h0);
        cyc();
        chk_all("reboot0", 32'h0, 0, 0, 32'h0, 0);
        cyc();
        chk_all("reboot1", 32'h0, 1, 1, 32'h0, 0);

        // Flush to a misaligned target.
        drive(0, 1, 0, 0, 1, 32'h42);
        cyc();
`ifdef PC_MISALIGN_TRAP_EN
        chk_all("mis", 32'h80, 1, 1, 32'h42, 1);
        chk("mis.pulse", {31'd0, misalign_pulse}, 32'd1);
        drive(0, 0, 0, 0, 1, 32'h0);
        cyc();
        chk_all("mis.after", 32'h84, 1, 1, 32'h42, 1);
        chk("mis.pulse_off", {31'd0, misalign_pulse}, 32'd0);
`else
        chk_all("mis", 32'h40, 1, 1, 32'h0, 1);
        drive(0, 0, 0, 0, 1, 32'h0);
        cyc();
        chk_all("mis.after", 32'h44, 1, 1, 32'h0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
